mips_trace_buffer: RTL
======================

Name: mips_trace_buffer

Overview:
- Synthesizable register-write trace unit for the single-cycle MIPS core.
- Snoops the register-file write port and captures each write to a selected register into an on-chip FIFO: timestamp, PC, register address, data.
- Drained over a valid/ready stream by a debug host or testbench.
- Generalises fixed three-register console monitoring ($t0–$t2) to any mask of the 32 GPRs, with buffering, backpressure and overflow accounting.

Parameters:
- DATA_W, 32, width of register data and PC
- DEPTH, 16, FIFO entries; power of two, ≥2
- TS_W, 16, free-running cycle-stamp width
- DROP_W, 8, dropped-entry counter width

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- trace_en  in  1  capture enable
- watch_mask  in  32  bit i=1 captures writes to register i; bit 0 ignored
- rf_we  in  1  register-file write enable from core
- rf_waddr  in  5  register-file write address
- rf_wdata  in  DATA_W  register-file write data
- pc  in  DATA_W  PC of the instruction performing the write
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head entry
- out_ts  out  TS_W  head timestamp
- out_pc  out  DATA_W  head PC
- out_addr  out  5  head register address
- out_data  out  DATA_W  head data
- level  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: at least one capture dropped
- drop_cnt  out  DROP_W  dropped captures, saturating
- clr  in  1  clears overflow and drop_cnt

Behaviour:
- Reset (reset=0 at a clk edge): FIFO empty, all out_* fields 0.
  - out_valid=0, level=0, overflow=0, drop_cnt=0, timestamp counter=0.
  - Reset mid-operation discards all contents; no partial pop completes.
- Timestamp: TS_W counter increments every cycle out of reset, wraps 2^TS_W-1 → 0. Entry records the counter value of its capture cycle.
- Capture condition: trace_en & rf_we & watch_mask[rf_waddr] & (rf_waddr != 0). Writes to $zero are never captured.
- Push: on a capture with FIFO not full, entry written at that edge.
  - out_valid rises the following cycle when previously empty (1-cycle latency, no combinational bypass).
- Pop: out_valid & out_ready at an edge advances the head.
  - out_* are registered/RAM-read values and remain stable while out_valid=1 and out_ready=0.
- Simultaneous push+pop:
  - Both occur; level unchanged.
  - When full, the pop frees a slot and the push is accepted (no drop).
  - When empty, only the push takes effect; the pop is ignored because out_valid=0.
- Full without pop: capture dropped; overflow set; drop_cnt increments, saturating at 2^DROP_W-1.
- clr: overflow and drop_cnt return to 0 next edge. A drop in the same cycle as clr wins: overflow=1, drop_cnt=1.
- Pointers: log2(DEPTH) bits, wrap naturally. level tracks occupancy 0..DEPTH; full ⇔ level==DEPTH.
- out_* when out_valid=0: hold last value, no meaning.
- trace_en deassert: stops new captures only; draining continues.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined: timestamp counter and out_ts storage as specified.
- Undefined: no counter and no TS field stored; out_ts tied to 0. FIFO entry width shrinks by TS_W; all other behaviour identical.

Decomposition:
- Package mips_trace_pkg holds:
  - entry struct/typedef {ts, pc, addr, data}
  - REG_ZERO=5'd0
  - ADDR_W=5
  - entry-width localparam helper
- Natural sub-module: trace_sync_fifo, a generic DEPTH × WIDTH synchronous FIFO with push/pop/level/full/empty.
- Top handles capture filtering, timestamp and overflow accounting.

Test Plan:
- Reset then watch_mask=0x0000_0700; core writes $t0=5, $t1=7, $t2=12 at cycles 3, 4, 5 with out_ready=1.
  → Three entries out in order, addr 8/9/10, data 5/7/12, ts 3/4/5; level returns to 0.
- Write $zero=0x55 and $t3=1 with mask 0xFFFF_FFFF.
  → Only the $t3 entry appears; no $zero entry.
- out_ready=0, 18 captures into DEPTH=16.
  → level=16, overflow=1, drop_cnt=2. The first 16 captures are drained intact after out_ready=1.
- Full FIFO, capture and pop in the same cycle.
  → level stays 16, drop_cnt unchanged, new entry present at the tail.
- Assert clr in the same cycle as a dropped capture.
  → overflow=1, drop_cnt=1. A later clr alone gives 0/0.
- Mid-drain reset=0 for one cycle.
  → out_valid=0, level=0, timestamp restarts at 0. Run with and without TRACE_TIMESTAMP_EN; out_ts=0 when undefined.

Source files
------------

// File: rtl/mips_trace_buffer_pkg.sv
// Shared types and helpers for the MIPS register-write trace unit.
// The TS field is present only when TRACE_TIMESTAMP_EN is defined.
package mips_trace_pkg;

  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  // Default-width entry layout; the top rebuilds it with its own parameter widths.
  typedef struct packed {
    logic [15:0]       ts;
    logic [31:0]       pc;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } trace_entry_t;

  function automatic int entry_width(input int data_w, input int ts_w, input bit ts_en);
    return 2 * data_w + ADDR_W + (ts_en ? ts_w : 0);
  endfunction

endpackage

// File: rtl/mips_trace_buffer_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with a registered head output.
// The head register resets to 0 and holds its last value while the FIFO is empty.
module trace_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             do_push, do_pop;

  always_comb begin
    empty    = (level_q == '0);
    full     = (level_q == LVL_W'(DEPTH));
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    level_d  = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    dout_d   = dout_q;
    // Preload the next head; a push landing on the new head slot bypasses the array.
    if (level_d != '0) begin
      if (do_push && (rd_ptr_d == wr_ptr_q)) dout_d = din;
      else                                   dout_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = dout_q;
  assign level = level_q;

endmodule

// File: rtl/mips_trace_buffer.sv
// Register-write trace unit: filters RF writes by mask, buffers them, counts drops.
// Define TRACE_TIMESTAMP_EN to store a free-running cycle stamp with each entry.
module mips_trace_buffer
  import mips_trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  parameter int DROP_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   trace_en,
  input  logic [31:0]            watch_mask,
  input  logic                   rf_we,
  input  logic [ADDR_W-1:0]      rf_waddr,
  input  logic [DATA_W-1:0]      rf_wdata,
  input  logic [DATA_W-1:0]      pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TS_W-1:0]        out_ts,
  output logic [DATA_W-1:0]      out_pc,
  output logic [ADDR_W-1:0]      out_addr,
  output logic [DATA_W-1:0]      out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clr,
  output logic [DROP_W-1:0]      drop_cnt
);

`ifdef TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] pc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;
`else
  localparam bit TS_EN = 1'b0;
  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;
`endif

  localparam int ENTRY_W = entry_width(DATA_W, TS_W, TS_EN);

  entry_t              wr_entry, rd_entry;
  logic                capture, pop_fire, drop, fifo_full, fifo_empty;
  logic                overflow_q, overflow_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

  always_comb begin
    capture  = trace_en & rf_we & watch_mask[rf_waddr] & (rf_waddr != REG_ZERO);
    pop_fire = ~fifo_empty & out_ready;
    drop     = capture & fifo_full & ~pop_fire;
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;

  always_comb ts_d = ts_q + TS_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) ts_q <= '0;
    else        ts_q <= ts_d;
  end

  always_comb begin
    wr_entry = '{ts: ts_q, pc: pc, addr: rf_waddr, data: rf_wdata};
    out_ts   = rd_entry.ts;
  end
`else
  always_comb begin
    wr_entry = '{pc: pc, addr: rf_waddr, data: rf_wdata};
    out_ts   = '0;
  end
`endif

  trace_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (capture),
    .din   (wr_entry),
    .pop   (out_ready),
    .dout  (rd_entry),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A drop in the same cycle as clr leaves exactly that one drop recorded.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clr)                              drop_cnt_d = DROP_W'(1);
      else if (drop_cnt_q != {DROP_W{1'b1}}) drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end else if (clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_valid = ~fifo_empty;
  assign out_pc    = rd_entry.pc;
  assign out_addr  = rd_entry.addr;
  assign out_data  = rd_entry.data;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
